// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared defaults and types for the on-chip RAM arbiter
package onchip_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  typedef logic master_id_t;
endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// onchip_memory_arbiter_if: one Avalon-MM master port into the RAM arbiter
interface onchip_memory_arbiter_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_rr_arbiter.sv
// onchip_rr_arbiter: two-way round-robin grant with last-grant pointer
module onchip_rr_arbiter
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output master_id_t gnt_id
);
  master_id_t last;
  always_comb begin
    gnt_valid = en & |req;
    gnt_id    = &req ? ~last : req[1];
  end
  // starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last <= 1'b1;
    else if (gnt_valid) last <= gnt_id;
endmodule

// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter: two-master round-robin arbiter and zero-fill sequencer
// for a single-port RAM with 1-cycle read latency
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  onchip_memory_arbiter_if.slave  m0,
  onchip_memory_arbiter_if.slave  m1,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W/8-1:0]     mem_byteenable,
  output logic                    mem_chipselect,
  output logic                    mem_write,
  output logic [DATA_W-1:0]       mem_writedata,
  output logic                    mem_clken,
  input  logic [DATA_W-1:0]       mem_readdata
);
  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        req;
  logic              gnt_valid, gnt_write, clearing, fill_done, tag_valid;
  master_id_t        gnt_id, tag_id;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  onchip_rr_arbiter u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (state == ST_IDLE),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    clearing       = state == ST_CLEAR;
    fill_done      = cnt == ADDR_W'(DEPTH - 1);
    next_state     = clearing ? (fill_done ? ST_IDLE : ST_CLEAR) : (clear_req ? ST_CLEAR : ST_IDLE);
    gnt_write      = gnt_id ? m1.write : m0.write;
    clear_busy     = clearing;
    m0.waitrequest = clearing | (req[0] & ~(gnt_valid & ~gnt_id));
    m1.waitrequest = clearing | (req[1] & ~(gnt_valid & gnt_id));
    mem_address    = clearing ? cnt : (gnt_id ? m1.address : m0.address);
    mem_byteenable = clearing ? '1 : (gnt_id ? m1.byteenable : m0.byteenable);
    mem_writedata  = clearing ? '0 : (gnt_id ? m1.writedata : m0.writedata);
    mem_chipselect = clearing | gnt_valid;
    mem_write      = clearing | (gnt_valid & gnt_write);
    mem_clken      = 1'b1;
    m0.readdatavalid = tag_valid & ~tag_id;
    m1.readdatavalid = tag_valid & tag_id;
    m0.readdata      = (tag_valid & ~tag_id) ? mem_readdata : '0;
    m1.readdata      = (tag_valid & tag_id) ? mem_readdata : '0;
  end

  // the read tag tracks the RAM's fixed one-cycle latency
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= (clearing & ~fill_done) ? cnt + 1'b1 : '0;
      tag_valid <= gnt_valid & ~gnt_write;
      tag_id    <= gnt_id;
    end
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb_onchip_memory_arbiter: vector table, directed corner cases and a randomized
// run against a rule-level arbitration and memory model
module tb_onchip_memory_arbiter;
  import onchip_arb_pkg::*;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] ex;
    logic [1:0] ev;
    logic [9:0] ea;
  } vec_t;

  localparam logic [9:0] A0 = 10'h010;
  localparam logic [9:0] A1 = 10'h020;

  logic        clk = 1'b0, reset_n = 1'b0, clear_req = 1'b0;
  logic        clear_busy, mem_chipselect, mem_write, mem_clken;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] ram [1024];
  logic [31:0] shadow [1024];
  logic        bd_we = 1'b0, bd_fill = 1'b0;
  logic [9:0]  bd_a = '0;
  logic [31:0] bd_d = '0;
  int          tests = 0, fails = 0, n;
  vec_t        tbl [10];
  logic        q0, q1, r0, w0, r1, w1, any, g, lst, gw, pv0, pv1;
  logic [9:0]  a0, a1, ga;
  logic [3:0]  be0, be1, gbe;
  logic [31:0] d0, d1, gd, pd;

  onchip_memory_arbiter_if m0 ();
  onchip_memory_arbiter_if m1 ();

  onchip_memory_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0),
    .m1             (m1),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // RAM: byte-lane writes, registered reads, plus a backdoor for preloading
  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else if (bd_we) begin
      ram[bd_a] <= bd_d;
    end else if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end else if (mem_chipselect) begin
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic w, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    m0.read = r; m0.write = w; m0.address = a; m0.byteenable = be; m0.writedata = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    m1.read = r; m1.write = w; m1.address = a; m1.byteenable = be; m1.writedata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
    bd_a = a; bd_d = d; bd_we = 1'b1;
    nxt();
    bd_we = 1'b0;
  endtask

  task automatic fill_pat();
    bd_fill = 1'b1;
    nxt();
    bd_fill = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; clear_req = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic rd_check(input string nm, input logic [9:0] a, input logic [31:0] e);
    drv0(1'b1, 1'b0, a, 4'hF, '0);
    nxt();
    idle();
    @(negedge clk);
    chk({nm, " valid"}, m0.readdatavalid, 1'b1);
    chk({nm, " data"}, m0.readdata, e);
    nxt();
  endtask

  task automatic count_busy(output int k);
    k = 0;
    while (clear_busy && k < 2000) begin
      k++;
      nxt();
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 2'b00, 10'h000};
    tbl[1] = '{4'b1000, 4'b0010, 2'b00, A0};
    tbl[2] = '{4'b1010, 4'b1010, 2'b10, A1};
    tbl[3] = '{4'b1010, 4'b0110, 2'b01, A0};
    tbl[4] = '{4'b0001, 4'b0011, 2'b10, A1};
    tbl[5] = '{4'b1110, 4'b0111, 2'b00, A0};
    tbl[6] = '{4'b0101, 4'b1011, 2'b00, A1};
    tbl[7] = '{4'b0010, 4'b0010, 2'b00, A1};
    tbl[8] = '{4'b1010, 4'b0110, 2'b01, A0};
    tbl[9] = '{4'b0000, 4'b0000, 2'b10, 10'h000};

    idle();
    fill_pat();
    @(negedge clk);
    chk("reset busy", clear_busy, 1'b0);
    chk("reset cs", mem_chipselect, 1'b0);
    chk("reset we", mem_write, 1'b0);
    chk("reset rdv0", m0.readdatavalid, 1'b0);
    chk("reset rdv1", m1.readdatavalid, 1'b0);
    chk("reset rd0", m0.readdata, 32'h0);
    chk("clken", mem_clken, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (tbl[i]) begin
      drv0(tbl[i].req[3], tbl[i].req[2], A0, 4'hF, 32'h1000_0000 + 32'(i));
      drv1(tbl[i].req[1], tbl[i].req[0], A1, 4'hF, 32'h2000_0000 + 32'(i));
      @(negedge clk);
      chk("tbl wait0", m0.waitrequest, tbl[i].ex[3]);
      chk("tbl wait1", m1.waitrequest, tbl[i].ex[2]);
      chk("tbl cs", mem_chipselect, tbl[i].ex[1]);
      chk("tbl we", mem_write, tbl[i].ex[0]);
      if (tbl[i].ex[1]) chk("tbl addr", 32'(mem_address), 32'(tbl[i].ea));
      chk("tbl rdv0", m0.readdatavalid, tbl[i].ev[1]);
      chk("tbl rdv1", m1.readdatavalid, tbl[i].ev[0]);
      nxt();
    end
    idle();

    backdoor(10'h005, 32'hDEAD_BEEF);
    drv0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    @(negedge clk);
    chk("lone wait0", m0.waitrequest, 1'b0);
    chk("lone cs", mem_chipselect, 1'b1);
    chk("lone addr", 32'(mem_address), 32'h005);
    nxt();
    idle();
    @(negedge clk);
    chk("lone rdv0", m0.readdatavalid, 1'b1);
    chk("lone rd0", m0.readdata, 32'hDEAD_BEEF);
    chk("lone rdv1", m1.readdatavalid, 1'b0);
    chk("lone rd1", m1.readdata, 32'h0);
    nxt();

    backdoor(10'h3FF, 32'hFFFF_FFFF);
    drv1(1'b0, 1'b1, 10'h3FF, 4'b0101, 32'h1122_3344);
    @(negedge clk);
    chk("bw wait1", m1.waitrequest, 1'b0);
    chk("bw we", mem_write, 1'b1);
    chk("bw be", 32'(mem_byteenable), 32'h5);
    nxt();
    drv1(1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    nxt();
    idle();
    @(negedge clk);
    chk("bw rdv1", m1.readdatavalid, 1'b1);
    chk("bw rd1", m1.readdata, 32'hFF22_FF44);
    nxt();

    fill_pat();
    do_reset();
    drv0(1'b1, 1'b0, 10'h040, 4'hF, '0);
    drv1(1'b1, 1'b0, 10'h041, 4'hF, '0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle();
      @(negedge clk);
      if (k < 4) begin
        chk("cont wait0", m0.waitrequest, (k % 2) == 1);
        chk("cont wait1", m1.waitrequest, (k % 2) == 0);
      end
      if (k > 0) begin
        chk("cont rdv0", m0.readdatavalid, ((k - 1) % 2) == 0);
        chk("cont rdv1", m1.readdatavalid, ((k - 1) % 2) == 1);
        chk("cont data", ((k - 1) % 2) == 0 ? m0.readdata : m1.readdata,
            ((k - 1) % 2) == 0 ? pat('h40) : pat('h41));
      end
      nxt();
    end

    drv0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    nxt();
    idle();
    reset_n = 1'b0;
    #1;
    chk("rst drops rdv0", m0.readdatavalid, 1'b0);
    nxt();
    reset_n = 1'b1;

    clear_req = 1'b1;
    @(negedge clk);
    chk("clr pulse busy", clear_busy, 1'b0);
    nxt();
    clear_req = 1'b0;
    drv0(1'b1, 1'b0, 10'h003, 4'hF, '0);
    drv1(1'b1, 1'b0, 10'h004, 4'hF, '0);
    @(negedge clk);
    chk("fill wait0", m0.waitrequest, 1'b1);
    chk("fill wait1", m1.waitrequest, 1'b1);
    chk("fill we", mem_write, 1'b1);
    chk("fill addr", 32'(mem_address), 32'h0);
    chk("fill wdata", mem_writedata, 32'h0);
    chk("fill be", 32'(mem_byteenable), 32'hF);
    count_busy(n);
    chk("fill length", n, 1024);
    nxt();
    idle();
    nxt();
    n = 0;
    foreach (ram[i]) if (ram[i] != 32'h0) n++;
    chk("fill nonzero words", n, 0);
    rd_check("fill rd 000", 10'h000, 32'h0);
    rd_check("fill rd 3ff", 10'h3FF, 32'h0);

    fill_pat();
    drv0(1'b1, 1'b0, 10'h007, 4'hF, '0);
    clear_req = 1'b1;
    @(negedge clk);
    chk("edge wait0", m0.waitrequest, 1'b0);
    chk("edge cs", mem_chipselect, 1'b1);
    nxt();
    idle();
    clear_req = 1'b0;
    @(negedge clk);
    chk("edge rdv0", m0.readdatavalid, 1'b1);
    chk("edge rd0", m0.readdata, pat(7));
    chk("edge busy", clear_busy, 1'b1);
    count_busy(n);
    chk("edge fill length", n, 1024);
    nxt();

    fill_pat();
    clear_req = 1'b1;
    nxt();
    clear_req = 1'b0;
    repeat (500) nxt();
    @(negedge clk);
    chk("mid busy", clear_busy, 1'b1);
    chk("mid addr", 32'(mem_address), 32'd500);
    reset_n = 1'b0;
    #1;
    chk("mid rst busy", clear_busy, 1'b0);
    chk("mid rst cs", mem_chipselect, 1'b0);
    nxt();
    nxt();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid no resume", clear_busy, 1'b0);
    nxt();
    rd_check("mid rd 499", 10'd499, 32'h0);
    rd_check("mid rd 500", 10'd500, pat(500));
    rd_check("mid rd 1023", 10'd1023, pat(1023));

    fill_pat();
    do_reset();
    for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
    lst = 1'b1; pv0 = 1'b0; pv1 = 1'b0; pd = '0;
    for (int c = 0; c < 500; c++) begin
      q0 = ($urandom % 3) != 0;
      q1 = ($urandom % 3) != 0;
      w0 = q0 && ($urandom % 2 == 1);
      r0 = q0 && (!w0 || ($urandom % 2 == 1));
      w1 = q1 && ($urandom % 2 == 1);
      r1 = q1 && (!w1 || ($urandom % 2 == 1));
      a0 = {($urandom % 2 == 1) ? 6'h3F : 6'h00, 4'($urandom)};
      a1 = {($urandom % 2 == 1) ? 6'h3F : 6'h00, 4'($urandom)};
      be0 = 4'($urandom); be1 = 4'($urandom);
      d0 = $urandom; d1 = $urandom;
      drv0(r0, w0, a0, be0, d0);
      drv1(r1, w1, a1, be1, d1);
      any = q0 | q1;
      g   = (q0 & q1) ? ~lst : q1;
      gw  = g ? w1 : w0;
      ga  = g ? a1 : a0;
      gbe = g ? be1 : be0;
      gd  = g ? d1 : d0;
      @(negedge clk);
      chk("rnd wait0", m0.waitrequest, q0 & ~(any & ~g));
      chk("rnd wait1", m1.waitrequest, q1 & ~(any & g));
      chk("rnd cs", mem_chipselect, any);
      if (any) begin
        chk("rnd we", mem_write, gw);
        chk("rnd addr", 32'(mem_address), 32'(ga));
      end
      if (any & gw) begin
        chk("rnd be", 32'(mem_byteenable), 32'(gbe));
        chk("rnd wdata", mem_writedata, gd);
      end
      chk("rnd rdv0", m0.readdatavalid, pv0);
      chk("rnd rdv1", m1.readdatavalid, pv1);
      chk("rnd rd0", m0.readdata, pv0 ? pd : 32'h0);
      chk("rnd rd1", m1.readdata, pv1 ? pd : 32'h0);
      pv0 = any & ~gw & ~g;
      pv1 = any & ~gw & g;
      pd  = shadow[ga];
      if (any & gw)
        for (int b = 0; b < 4; b++) if (gbe[b]) shadow[ga][8*b +: 8] = gd[8*b +: 8];
      if (any) lst = g;
      nxt();
    end
    idle();
    @(negedge clk);
    chk("rnd last rdv0", m0.readdatavalid, pv0);
    chk("rnd last rdv1", m1.readdatavalid, pv1);
    n = 0;
    foreach (ram[i]) if (ram[i] !== shadow[i]) n++;
    chk("rnd ram contents", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
